// File: rtl/disk_access_arbiter_if.sv
// Request, disk and completion signals of the disk access arbiter.
// slave: arbiter side; master: requesters and disk reader side.
interface disk_access_arbiter_if;
  logic        rd_req;
  logic [7:0]  rd_add;
  logic        rmw_req;
  logic [7:0]  rmw_add;
  logic        rd_gnt;
  logic        rmw_gnt;
  logic        disk_rd_en;
  logic [7:0]  disk_add;
  logic [1:0]  en_rd_mem;
  logic        disk_valid;
  logic [11:0] disk_data_A;
  logic [11:0] disk_data_B;
  logic        rd_done;
  logic        rmw_done;
  logic [11:0] data_A;
  logic [11:0] data_B;
  logic        timeout_err;
  logic        busy;

  modport slave (
    input  rd_req, rd_add, rmw_req, rmw_add,
    input  disk_valid, disk_data_A, disk_data_B,
    output rd_gnt, rmw_gnt, disk_rd_en, disk_add, en_rd_mem,
    output rd_done, rmw_done, data_A, data_B, timeout_err, busy
  );

  modport master (
    output rd_req, rd_add, rmw_req, rmw_add,
    output disk_valid, disk_data_A, disk_data_B,
    input  rd_gnt, rmw_gnt, disk_rd_en, disk_add, en_rd_mem,
    input  rd_done, rmw_done, data_A, data_B, timeout_err, busy
  );
endinterface

// File: rtl/disk_access_arbiter.sv
// Round-robin arbiter between user reads and read-for-write disk reads.
// Optional WAIT timeout enabled by defining DISK_TIMEOUT_EN.
module disk_access_arbiter #(
  parameter int TIMEOUT_CYC = 64
) (
  input logic clk,
  input logic reset_n,
  disk_access_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;
  logic        last_rmw;
  logic        owner_rmw;
  logic        any_req;
  logic        pick_rmw;
  logic [7:0]  pick_add;
  logic        expire;

  logic        rd_gnt_q;
  logic        rmw_gnt_q;
  logic        rd_en_q;
  logic [7:0]  add_q;
  logic [1:0]  en_q;
  logic        rd_done_q;
  logic        rmw_done_q;
  logic [11:0] data_a_q;
  logic [11:0] data_b_q;
  logic        to_q;
  logic        busy_q;

  // Data disk enable: the parity disk index is (add mod 3), inverted.
  function automatic logic [1:0] mem_en(input logic [7:0] a);
    logic [7:0] m;
    m = a % 8'd3;
    return ~m[1:0];
  endfunction

  assign any_req  = bus.rd_req | bus.rmw_req;
  // On a tie the requester that did not win last time goes first.
  assign pick_rmw = bus.rmw_req & (~bus.rd_req | ~last_rmw);
  assign pick_add = pick_rmw ? bus.rmw_add : bus.rd_add;

`ifdef DISK_TIMEOUT_EN
  logic [7:0] cnt;

  assign expire = (state == WAIT) && !bus.disk_valid &&
                  (cnt == 8'(TIMEOUT_CYC - 1));

  // WAIT cycle counter, cleared while the read is being issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 8'd0;
    end else if (state == ISSUE) begin
      cnt <= 8'd0;
    end else if (state == WAIT) begin
      cnt <= cnt + 8'd1;
    end
  end
`else
  logic [7:0] unused_cfg;

  assign unused_cfg = 8'(TIMEOUT_CYC);
  assign expire     = 1'b0;
`endif

  // Transaction FSM with registered grant, strobe and completion outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_rmw   <= 1'b1;
      owner_rmw  <= 1'b0;
      rd_gnt_q   <= 1'b0;
      rmw_gnt_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      add_q      <= 8'd0;
      en_q       <= 2'd0;
      rd_done_q  <= 1'b0;
      rmw_done_q <= 1'b0;
      data_a_q   <= 12'd0;
      data_b_q   <= 12'd0;
      to_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rd_gnt_q   <= 1'b0;
      rmw_gnt_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_done_q  <= 1'b0;
      rmw_done_q <= 1'b0;
      to_q       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ISSUE;
            owner_rmw <= pick_rmw;
            last_rmw  <= pick_rmw;
            rd_gnt_q  <= ~pick_rmw;
            rmw_gnt_q <= pick_rmw;
            rd_en_q   <= 1'b1;
            add_q     <= pick_add;
            en_q      <= mem_en(pick_add);
            busy_q    <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (bus.disk_valid) begin
            state      <= DONE;
            data_a_q   <= bus.disk_data_A;
            data_b_q   <= bus.disk_data_B;
            rd_done_q  <= ~owner_rmw;
            rmw_done_q <= owner_rmw;
          end else if (expire) begin
            state  <= IDLE;
            to_q   <= 1'b1;
            add_q  <= 8'd0;
            en_q   <= 2'd0;
            busy_q <= 1'b0;
          end
        end
        DONE: begin
          state  <= IDLE;
          add_q  <= 8'd0;
          en_q   <= 2'd0;
          busy_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_gnt      = rd_gnt_q;
  assign bus.rmw_gnt     = rmw_gnt_q;
  assign bus.disk_rd_en  = rd_en_q;
  assign bus.disk_add    = add_q;
  assign bus.en_rd_mem   = en_q;
  assign bus.rd_done     = rd_done_q;
  assign bus.rmw_done    = rmw_done_q;
  assign bus.data_A      = data_a_q;
  assign bus.data_B      = data_b_q;
  assign bus.timeout_err = to_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_disk_access_arbiter.sv
// Self-checking bench for disk_access_arbiter: directed scenarios
// plus randomized traffic against a transaction-level model.
module tb_disk_access_arbiter;

  localparam int T = 4;
`ifdef DISK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  disk_access_arbiter_if bus();

  disk_access_arbiter #(
    .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // {rd_gnt, rmw_gnt, disk_rd_en, rd_done, rmw_done, timeout_err, busy}
  logic [6:0] ctrl;
  assign ctrl = {bus.rd_gnt, bus.rmw_gnt, bus.disk_rd_en,
                 bus.rd_done, bus.rmw_done, bus.timeout_err, bus.busy};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.rd_req = 1'b0;
    bus.rd_add = 8'h00;
    bus.rmw_req = 1'b0;
    bus.rmw_add = 8'h00;
    bus.disk_valid = 1'b0;
    bus.disk_data_A = 12'h000;
    bus.disk_data_B = 12'h000;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    cyc(); cyc(); smp();
    checks++;
    if ({ctrl, bus.disk_add, bus.en_rd_mem, bus.data_A, bus.data_B} !== 41'd0) begin
      failures++;
      $display("FAIL reset_outputs got ctrl=%b add=%h en=%b", ctrl, bus.disk_add, bus.en_rd_mem);
    end
    reset_n = 1'b1;
    cyc(); smp();
    checks++;
    if (ctrl !== 7'b0) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=0000000", ctrl);
    end
  endtask

  task automatic test_basic_read();
    cyc(); bus.rd_req = 1'b1; bus.rd_add = 8'h05; smp();
    checks++;
    if (ctrl !== 7'b0) begin
      failures++; $display("FAIL basic_cycle_n got=%b exp=0000000", ctrl);
    end
    cyc(); smp();
    checks++;
    if ({ctrl, bus.disk_add, bus.en_rd_mem} !== {7'b1010001, 8'h05, 2'b01}) begin
      failures++;
      $display("FAIL basic_issue got ctrl=%b add=%h en=%b exp 1010001/05/01", ctrl, bus.disk_add, bus.en_rd_mem);
    end
    cyc(); bus.rd_req = 1'b0; smp();
    checks++;
    if (ctrl !== 7'b0000001) begin
      failures++; $display("FAIL basic_wait got=%b exp=0000001", ctrl);
    end
    cyc(); smp();
    cyc(); bus.disk_valid = 1'b1; bus.disk_data_A = 12'hABC; bus.disk_data_B = 12'h123; smp();
    cyc(); bus.disk_valid = 1'b0; smp();
    checks++;
    if ({ctrl, bus.data_A, bus.data_B, bus.disk_add} !== {7'b0001001, 12'hABC, 12'h123, 8'h05}) begin
      failures++;
      $display("FAIL basic_done got ctrl=%b A=%h B=%h add=%h", ctrl, bus.data_A, bus.data_B, bus.disk_add);
    end
    cyc(); smp();
    checks++;
    if ({ctrl, bus.disk_add, bus.en_rd_mem, bus.data_A} !== {7'b0, 8'h00, 2'b00, 12'hABC}) begin
      failures++;
      $display("FAIL basic_idle got ctrl=%b add=%h en=%b A=%h", ctrl, bus.disk_add, bus.en_rd_mem, bus.data_A);
    end
  endtask

  task automatic test_tie();
    reset_n = 1'b0;
    bus.rd_req = 1'b1; bus.rd_add = 8'h10;
    bus.rmw_req = 1'b1; bus.rmw_add = 8'h03;
    cyc(); cyc();
    @(negedge clk); reset_n = 1'b1;
    cyc(); smp();
    checks++;
    if ({ctrl, bus.disk_add, bus.en_rd_mem} !== {7'b1010001, 8'h10, 2'b10}) begin
      failures++;
      $display("FAIL tie_first_rd got ctrl=%b add=%h en=%b", ctrl, bus.disk_add, bus.en_rd_mem);
    end
    cyc(); bus.rd_req = 1'b0; bus.disk_valid = 1'b1;
    bus.disk_data_A = 12'h111; bus.disk_data_B = 12'h222; smp();
    cyc(); bus.disk_valid = 1'b0; smp();
    checks++;
    if (ctrl !== 7'b0001001) begin
      failures++; $display("FAIL tie_rd_done got=%b exp=0001001", ctrl);
    end
    cyc(); smp();
    checks++;
    if (ctrl !== 7'b0) begin
      failures++; $display("FAIL tie_gap got=%b exp=0000000", ctrl);
    end
    cyc(); smp();
    checks++;
    if ({ctrl, bus.disk_add, bus.en_rd_mem} !== {7'b0110001, 8'h03, 2'b11}) begin
      failures++;
      $display("FAIL tie_rmw_gnt got ctrl=%b add=%h en=%b", ctrl, bus.disk_add, bus.en_rd_mem);
    end
    cyc(); bus.rmw_req = 1'b0; bus.rd_req = 1'b1; bus.disk_valid = 1'b1;
    bus.disk_data_A = 12'h333; bus.disk_data_B = 12'h444; smp();
    cyc(); bus.disk_valid = 1'b0; bus.rmw_req = 1'b1; smp();
    checks++;
    if ({ctrl, bus.data_A, bus.data_B} !== {7'b0000101, 12'h333, 12'h444}) begin
      failures++;
      $display("FAIL tie_rmw_done got ctrl=%b A=%h B=%h", ctrl, bus.data_A, bus.data_B);
    end
    cyc(); smp();
    cyc(); smp();
    checks++;
    if (ctrl !== 7'b1010001) begin
      failures++; $display("FAIL tie_second_rd got=%b exp=1010001", ctrl);
    end
    cyc(); bus.rd_req = 1'b0; bus.disk_valid = 1'b1;
    bus.disk_data_A = 12'h777; bus.disk_data_B = 12'h888; smp();
    cyc(); bus.disk_valid = 1'b0; bus.rmw_req = 1'b0; smp();
    checks++;
    if ({ctrl, bus.data_A} !== {7'b0001001, 12'h777}) begin
      failures++; $display("FAIL tie_rd2_done got ctrl=%b A=%h", ctrl, bus.data_A);
    end
    cyc(); smp();
    cyc(); smp();
    checks++;
    if (ctrl !== 7'b0) begin
      failures++; $display("FAIL withdrawn_req got=%b exp=0000000", ctrl);
    end
  endtask

  task automatic test_idle_valid(input logic [11:0] a, input logic [11:0] b);
    cyc(); bus.disk_valid = 1'b1; bus.disk_data_A = 12'hFFF; bus.disk_data_B = 12'hFFF; smp();
    cyc(); bus.disk_valid = 1'b0; smp();
    checks++;
    if ({ctrl, bus.data_A, bus.data_B} !== {7'b0, a, b}) begin
      failures++;
      $display("FAIL idle_valid got ctrl=%b A=%h B=%h exp A=%h B=%h", ctrl, bus.data_A, bus.data_B, a, b);
    end
  endtask

  task automatic test_mod3();
    logic [1:0] exp_en;
    logic [7:0] exp_add;
    for (int i = 0; i < 2; i++) begin
      exp_en  = (i == 0) ? 2'b11 : 2'b10;
      exp_add = (i == 0) ? 8'hFF : 8'h01;
      cyc();
      if (i == 0) begin bus.rmw_req = 1'b1; bus.rmw_add = 8'hFF; end
      else begin bus.rd_req = 1'b1; bus.rd_add = 8'h01; end
      smp();
      cyc(); smp();
      checks++;
      if ({bus.en_rd_mem, bus.disk_add} !== {exp_en, exp_add}) begin
        failures++;
        $display("FAIL mod3_%0d got en=%b add=%h exp en=%b add=%h", i, bus.en_rd_mem, bus.disk_add, exp_en, exp_add);
      end
      cyc(); bus.rd_req = 1'b0; bus.rmw_req = 1'b0; bus.disk_valid = 1'b1;
      bus.disk_data_A = 12'h0AA; bus.disk_data_B = 12'h0BB; smp();
      cyc(); bus.disk_valid = 1'b0; smp();
      cyc(); smp();
    end
  endtask

`ifdef DISK_TIMEOUT_EN
  task automatic test_timeout();
    cyc(); bus.rd_req = 1'b1; bus.rd_add = 8'h07; smp();
    cyc(); smp();
    cyc(); bus.rd_req = 1'b0; smp();
    for (int k = 0; k < T; k++) begin
      checks++;
      if (ctrl !== 7'b0000001) begin
        failures++; $display("FAIL timeout_wait_%0d got=%b exp=0000001", k, ctrl);
      end
      cyc(); smp();
    end
    checks++;
    if ({ctrl, bus.data_A} !== {7'b0000010, 12'h0AA}) begin
      failures++; $display("FAIL timeout_err got ctrl=%b A=%h exp 0000010/0aa", ctrl, bus.data_A);
    end
    cyc(); smp();
    checks++;
    if (ctrl !== 7'b0) begin
      failures++; $display("FAIL timeout_idle got=%b exp=0000000", ctrl);
    end
    cyc(); bus.rd_req = 1'b1; smp();
    cyc(); smp();
    cyc(); bus.rd_req = 1'b0; smp();
    for (int k = 1; k < T; k++) begin
      cyc();
      if (k == T - 1) begin
        bus.disk_valid = 1'b1; bus.disk_data_A = 12'h5A5; bus.disk_data_B = 12'hA5A;
      end
      smp();
    end
    cyc(); bus.disk_valid = 1'b0; smp();
    checks++;
    if ({ctrl, bus.data_A} !== {7'b0001001, 12'h5A5}) begin
      failures++; $display("FAIL expiry_valid got ctrl=%b A=%h exp 0001001/5a5", ctrl, bus.data_A);
    end
    cyc(); smp();
  endtask
`else
  task automatic test_no_timeout();
    cyc(); bus.rd_req = 1'b1; bus.rd_add = 8'h07; smp();
    cyc(); smp();
    cyc(); bus.rd_req = 1'b0; smp();
    for (int k = 0; k < 80; k++) begin
      checks++;
      if (ctrl !== 7'b0000001) begin
        failures++; $display("FAIL long_wait_%0d got=%b exp=0000001", k, ctrl);
      end
      cyc(); smp();
    end
    cyc(); bus.disk_valid = 1'b1; bus.disk_data_A = 12'h5A5; bus.disk_data_B = 12'hA5A; smp();
    cyc(); bus.disk_valid = 1'b0; smp();
    checks++;
    if ({ctrl, bus.data_A} !== {7'b0001001, 12'h5A5}) begin
      failures++; $display("FAIL long_wait_done got ctrl=%b A=%h", ctrl, bus.data_A);
    end
    cyc(); smp();
  endtask
`endif

  task automatic test_reset_mid_wait();
    cyc(); bus.rmw_req = 1'b1; bus.rmw_add = 8'h22; smp();
    cyc(); smp();
    checks++;
    if (ctrl !== 7'b0110001) begin
      failures++; $display("FAIL midwait_gnt got=%b exp=0110001", ctrl);
    end
    cyc(); bus.rmw_req = 1'b0; smp();
    cyc(); smp();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ctrl, bus.disk_add, bus.en_rd_mem, bus.data_A, bus.data_B} !== 41'd0) begin
      failures++;
      $display("FAIL midwait_reset got ctrl=%b add=%h en=%b A=%h", ctrl, bus.disk_add, bus.en_rd_mem, bus.data_A);
    end
    smp(); reset_n = 1'b1;
    cyc(); bus.disk_valid = 1'b1; bus.disk_data_A = 12'hFFF; bus.disk_data_B = 12'hFFF; smp();
    cyc(); bus.disk_valid = 1'b0; smp();
    checks++;
    if ({ctrl, bus.data_A, bus.disk_add} !== {7'b0, 12'h000, 8'h00}) begin
      failures++;
      $display("FAIL midwait_late_valid got ctrl=%b A=%h add=%h", ctrl, bus.data_A, bus.disk_add);
    end
  endtask

  task automatic test_random();
    bit         act = 1'b0;
    bit         own = 1'b0;
    bit         last = 1'b1;
    int         g = 0;
    int         v = -1;
    int         err_cyc = -1;
    logic [7:0] addr = 8'h00;
    logic [11:0] ma = 12'h000;
    logic [11:0] mb = 12'h000;
    bit         pend = 1'b0;
    int         cd = 0;
    bit         n_rd = 1'b0;
    bit         n_rmw = 1'b0;
    bit         n_dv = 1'b0;
    logic [7:0] n_rda = 8'h00;
    logic [7:0] n_rmwa = 8'h00;
    logic [11:0] n_a = 12'h000;
    logic [11:0] n_b = 12'h000;
    logic [6:0] e_ctrl;
    logic [7:0] e_add;
    logic [1:0] e_en;
    bit         e_g;
    bit         e_dn;

    reset_n = 1'b0;
    clear_inputs();
    cyc(); cyc();
    @(negedge clk); reset_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      bus.rd_req = n_rd; bus.rd_add = n_rda;
      bus.rmw_req = n_rmw; bus.rmw_add = n_rmwa;
      bus.disk_valid = n_dv; bus.disk_data_A = n_a; bus.disk_data_B = n_b;
      smp();

      e_g   = act && (c == g);
      e_dn  = act && (v >= 0) && (c == v + 1);
      e_ctrl = {e_g && !own, e_g && own, e_g, e_dn && !own, e_dn && own,
                c == err_cyc, act};
      e_add = act ? addr : 8'h00;
      e_en  = act ? 2'(3 - (addr % 3)) : 2'b00;
      checks++;
      if (ctrl !== e_ctrl) begin
        failures++; $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c, ctrl, e_ctrl);
      end
      checks++;
      if ({bus.disk_add, bus.en_rd_mem} !== {e_add, e_en}) begin
        failures++;
        $display("FAIL rnd_addr c=%0d got add=%h en=%b exp add=%h en=%b", c, bus.disk_add, bus.en_rd_mem, e_add, e_en);
      end
      checks++;
      if ({bus.data_A, bus.data_B} !== {ma, mb}) begin
        failures++;
        $display("FAIL rnd_data c=%0d got A=%h B=%h exp A=%h B=%h", c, bus.data_A, bus.data_B, ma, mb);
      end

      if (act) begin
        if (v >= 0) begin
          if (c == v + 1) act = 1'b0;
        end else if (c > g) begin
          if (bus.disk_valid) begin
            v = c; ma = bus.disk_data_A; mb = bus.disk_data_B;
          end else if (TO_EN && c == g + T) begin
            act = 1'b0; err_cyc = c + 1;
          end
        end
      end else if (bus.rd_req || bus.rmw_req) begin
        if (bus.rd_req && bus.rmw_req) own = !last;
        else own = bus.rmw_req;
        last = own;
        addr = own ? bus.rmw_add : bus.rd_add;
        g = c + 1; v = -1; act = 1'b1;
      end

      if (bus.rd_req && bus.rd_gnt) n_rd = 1'b0;
      else if (bus.rd_req && $urandom_range(0, 19) == 0) n_rd = 1'b0;
      else if (!bus.rd_req && $urandom_range(0, 3) == 0) begin
        n_rd = 1'b1; n_rda = 8'($urandom);
      end else n_rd = bus.rd_req;
      if (bus.rmw_req && bus.rmw_gnt) n_rmw = 1'b0;
      else if (bus.rmw_req && $urandom_range(0, 19) == 0) n_rmw = 1'b0;
      else if (!bus.rmw_req && $urandom_range(0, 3) == 0) begin
        n_rmw = 1'b1; n_rmwa = 8'($urandom);
      end else n_rmw = bus.rmw_req;

      if (bus.disk_rd_en) begin pend = 1'b1; cd = $urandom_range(0, 6); end
      n_dv = 1'b0;
      if (pend) begin
        if (cd == 0) begin n_dv = 1'b1; pend = 1'b0; end
        else cd--;
      end else if ($urandom_range(0, 9) == 0) n_dv = 1'b1;
      n_a = 12'($urandom); n_b = 12'($urandom);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_basic_read();
    test_tie();
    test_idle_valid(12'h777, 12'h888);
    test_mod3();
`ifdef DISK_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
